micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Parametrised microprogram sequencer for the ARM datapath control unit. It generalises the fixed 7-bit, 2-condition next-state logic to configurable microaddress width, control-field width and condition count. It adds conditional wait, micro-subroutine call/return with a hardware return stack, and stack error reporting. It drives an external combinational microstore and holds the current microword in a registered control register whose control field feeds the datapath.

## Interface
- AW, 7: microaddress width (microstore depth 2^AW).
- CW, 20: Moore control-field width driven to the datapath.
- NCOND, 4: number of condition inputs (≥2); CSW = $clog2(NCOND).
- STACK_DEPTH, 4: return-stack entries (≥1).
- Derived MW = 3+1+CSW+CW+AW (33 at defaults). Microword, MSB→LSB: op[2:0], inv, csel[CSW-1:0], ctl[CW-1:0], target[AW-1:0].
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- cond  in  NCOND  condition inputs (e.g. bit0 MOC, bit1 Cond).
- decode_addr  in  AW  entry address from the instruction encoder.
- uword  in  MW  microstore data for uaddr (combinational read).
- uaddr  out  AW  next microaddress to the microstore (combinational).
- ctl  out  CW  ctl field of the control register.
- cur_state  out  AW  address of the microword now in the control register.
- stack_err  out  1  sticky overflow/underflow flag.

## Operation
- sts = cond[csel] ^ inv, from the control-register fields and the live cond input. csel ≥ NCOND selects 0.
- uaddr is set by the control-register op:
  - 0 DECODE: decode_addr.
  - 1 JUMP: target.
  - 2 SEQ: cur_state+1.
  - 3 CJUMP: sts ? target : cur_state+1.
  - 4 CWAIT: sts ? cur_state+1 : cur_state (hold; ctl repeats).
  - 5 CALL: push cur_state+1, go to target.
  - 6 RET: pop, go to popped address.
  - 7 CRET: sts ? RET : cur_state+1.
- Address arithmetic is modulo 2^AW; cur_state = 2^AW−1 with SEQ wraps to 0.
- Each posedge (reset high): control register ← uword, cur_state ← uaddr, stack pointer updated.
- Stack overflow (CALL with STACK_DEPTH entries): the jump to target is still taken, the push is discarded, stack contents are unchanged, stack_err ← 1.
- Stack underflow (RET, or CRET with sts=1, on an empty stack): uaddr = 0, the pointer stays 0, stack_err ← 1.
- stack_err clears only on reset.

## Timing
- Reset (reset=0 at posedge):
  - Control register ← NOP word (op=JUMP, target=0, ctl=0, inv=0, csel=0).
  - cur_state ← 0, stack empty, stack_err ← 0.
  - Outputs after reset: ctl=0, cur_state=0, uaddr=0, stack_err=0.
- First posedge with reset=1: word 0 loads and cur_state=0. ctl shows word 0 from that edge on.
- Reset asserted mid-program or mid-wait aborts at the next posedge. No push or pop from the aborted word takes effect.
- Latency: a microword's ctl is valid for exactly one cycle (more under CWAIT). Branch decisions take effect at the next edge.
- cond and decode_addr must be stable before the posedge. uaddr depends combinationally on them (no registered path from cond to uaddr).
- A push or pop and its address selection happen in the same cycle. The stack top reads from the pre-edge pointer.

## Configuration
- MICRO_SEQ_STACK_EN defined: the return stack, CALL/RET/CRET and stack_err behave as described above.
- MICRO_SEQ_STACK_EN undefined:
  - No stack storage.
  - op 5 behaves as JUMP.
  - op 6 goes to 0.
  - op 7 gives sts ? 0 : cur_state+1.
  - stack_err is tied 0.

## Test plan
- Reset then SEQ chain: words 0..3 op=SEQ. Release reset → cur_state 0,1,2,3 on successive edges; ctl matches each word's ctl; ctl=0 during reset.
- DECODE/CJUMP: word 1 op=DECODE, decode_addr=64 → cur_state=64 next edge. Word 64 op=CJUMP csel=1 inv=0 target=1: with cond[1]=1 → 1; with cond[1]=0 → 65.
- CWAIT on MOC: op=4 csel=0 at address 10, cond[0]=0 for 3 cycles → cur_state stays 10 and ctl repeats for 3 cycles; cond[0]=1 → 11.
- Nested call: CALL 20→40, CALL 40→50, RET at 50 → 41; RET at 41 → 21; stack_err=0.
- Overflow/underflow (STACK_DEPTH=2): three CALLs → third still jumps, stack_err=1. After reset, RET on empty stack → cur_state=0, stack_err=1.
- Macro off: CALL 5→30 → 30, then RET → 0; stack_err stays 0.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: parametrised microprogram sequencer with conditional wait and micro-subroutine return stack
//   clk         clock, all state updates on posedge
//   reset       synchronous active-low reset
//   cond        condition inputs, selected by the csel field
//   decode_addr entry address used by DECODE words
//   uword       microstore data at uaddr (combinational read)
//   uaddr       next microaddress to the microstore (combinational)
//   ctl         control field of the registered microword
//   cur_state   address of the registered microword
//   stack_err   sticky return-stack overflow/underflow flag
// Define MICRO_SEQ_STACK_EN to build the return stack (CALL/RET/CRET, stack_err).
module micro_sequencer #(
  parameter int AW = 7,
  parameter int CW = 20,
  parameter int NCOND = 4,
  parameter int STACK_DEPTH = 4,
  localparam int CSW = $clog2(NCOND),
  localparam int MW = 4 + CSW + CW + AW
) (
  input  logic clk,
  input  logic reset,
  input  logic [NCOND-1:0] cond,
  input  logic [AW-1:0] decode_addr,
  input  logic [MW-1:0] uword,
  output logic [AW-1:0] uaddr,
  output logic [CW-1:0] ctl,
  output logic [AW-1:0] cur_state,
  output logic stack_err
);
  localparam logic [MW-1:0] NOP = {3'd1, {(MW-3){1'b0}}};
  if (NCOND < 2 || STACK_DEPTH < 1) begin : g_cfg_check
    $error("micro_sequencer: NCOND must be >= 2 and STACK_DEPTH >= 1");
  end
  logic [MW-1:0] cr;
  logic [2:0] op;
  logic inv;
  logic [CSW-1:0] csel;
  logic [AW-1:0] target, nxt, ret_addr;
  logic sts;
  assign {op, inv, csel, ctl, target} = cr;
  assign nxt = cur_state + AW'(1);
  // csel values beyond the populated conditions read as 0 before inversion
  assign sts = ((32'(csel) < NCOND) ? cond[csel] : 1'b0) ^ inv;
`ifdef MICRO_SEQ_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [AW-1:0] stk [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic pop_req, push, pop, err_set, err_q;
  assign pop_req = op == 3'd6 || (op == 3'd7 && sts);
  assign push = op == 3'd5 && 32'(sp) < STACK_DEPTH;
  assign pop = pop_req && sp != '0;
  // full CALL still jumps but drops the push; empty RET falls back to address 0
  assign err_set = (op == 3'd5 && !push) || (pop_req && sp == '0);
  assign ret_addr = pop ? stk[IW'(sp - SPW'(1))] : '0;
  assign stack_err = err_q;
  always_ff @(posedge clk)
    if (!reset) begin
      sp <= '0;
      err_q <= 1'b0;
    end else begin
      sp <= push ? sp + SPW'(1) : pop ? sp - SPW'(1) : sp;
      err_q <= err_q | err_set;
    end
  always_ff @(posedge clk)
    if (reset && push) stk[sp[IW-1:0]] <= nxt;
`else
  assign ret_addr = '0;
  assign stack_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      cr <= NOP;
      cur_state <= '0;
    end else begin
      cr <= uword;
      cur_state <= uaddr;
    end
  always_comb
    uaddr = op == 3'd0 ? decode_addr :
            (op == 3'd1 || op == 3'd5) ? target :
            op == 3'd3 ? (sts ? target : nxt) :
            op == 3'd4 ? (sts ? nxt : cur_state) :
            op == 3'd6 ? ret_addr :
            op == 3'd7 ? (sts ? ret_addr : nxt) : nxt;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: randomized and directed check of micro_sequencer against a queue-based program model
module tb_micro_sequencer;
  localparam int AW = 7, CW = 20, NC = 4, SD = 2, MW = 33, DEPTH = 128;
  logic clk = 0;
  logic reset = 0;
  logic [NC-1:0] cond = '0;
  logic [AW-1:0] decode_addr = '0;
  logic [MW-1:0] uword;
  logic [AW-1:0] uaddr, cur_state;
  logic [CW-1:0] ctl;
  logic stack_err;
  logic [MW-1:0] mem [DEPTH];
  int checks = 0, failures = 0;
  int m_pc = 0;
  logic [MW-1:0] m_word;
  int m_stk[$];
  bit m_err = 0, m_valid = 0;

  micro_sequencer #(.AW(AW), .CW(CW), .NCOND(NC), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .cond(cond), .decode_addr(decode_addr),
    .uword(uword), .uaddr(uaddr), .ctl(ctl), .cur_state(cur_state), .stack_err(stack_err)
  );

  assign uword = mem[uaddr];
  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mk(int op, int inv, int cs, int c, int t);
    return {op[2:0], inv[0], cs[1:0], c[19:0], t[6:0]};
  endfunction

  function automatic bit m_sts();
    int cs = int'(m_word[28:27]);
    return ((int'(cond) >> cs) & 1) != (m_word[29] ? 1 : 0);
  endfunction

  function automatic int m_ret();
`ifdef MICRO_SEQ_STACK_EN
    return m_stk.size() == 0 ? 0 : m_stk[$];
`else
    return 0;
`endif
  endfunction

  function automatic int exp_addr();
    int op = int'(m_word[32:30]);
    int t = int'(m_word[6:0]);
    int nx = (m_pc + 1) % DEPTH;
    bit s = m_sts();
    case (op)
      0: return int'(decode_addr);
      1, 5: return t;
      3: return s ? t : nx;
      4: return s ? nx : m_pc;
      6: return m_ret();
      7: return s ? m_ret() : nx;
      default: return nx;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    int na, op;
    bit s, do_push, do_pop, set_err;
    logic [MW-1:0] nw;
    #1;
    if (m_valid) begin
      chk("uaddr", 32'(uaddr), exp_addr());
      chk("cur_state", 32'(cur_state), m_pc);
      chk("ctl", 32'(ctl), 32'(m_word[26:7]));
      chk("stack_err", 32'(stack_err), 32'(m_err));
    end
    do_push = 0; do_pop = 0; set_err = 0;
    op = int'(m_word[32:30]);
    s = m_sts();
    if (!reset) begin
      na = 0;
      nw = mk(1, 0, 0, 0, 0);
    end else begin
      na = exp_addr();
      nw = mem[na];
`ifdef MICRO_SEQ_STACK_EN
      if (op == 5) begin
        if (m_stk.size() < SD) do_push = 1; else set_err = 1;
      end
      if (op == 6 || (op == 7 && s)) begin
        if (m_stk.size() > 0) do_pop = 1; else set_err = 1;
      end
`endif
    end
    @(posedge clk);
    if (!reset) begin
      m_stk.delete();
      m_err = 0;
    end else begin
      if (do_push) m_stk.push_back((m_pc + 1) % DEPTH);
      if (do_pop) void'(m_stk.pop_back());
      if (set_err) m_err = 1;
    end
    m_pc = na;
    m_word = nw;
    m_valid = 1;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 0;
    repeat (n) tick();
    reset = 1;
  endtask

  initial begin
    clear_mem();
    @(negedge clk);
    // reset then SEQ chain
    for (int i = 0; i < 4; i++) mem[i] = mk(2, 0, 0, i + 1, 0);
    do_reset(2);
    #1;
    chk("rst_ctl", 32'(ctl), 0);
    chk("rst_cur", 32'(cur_state), 0);
    chk("rst_uaddr", 32'(uaddr), 0);
    chk("rst_err", 32'(stack_err), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_cur", 32'(cur_state), i);
      chk("seq_ctl", 32'(ctl), i + 1);
    end
    // DECODE and CJUMP
    clear_mem();
    mem[0] = mk(2, 0, 0, 5, 0);
    mem[1] = mk(0, 0, 0, 6, 0);
    mem[64] = mk(3, 0, 1, 7, 1);
    decode_addr = 7'd64;
    do_reset(1);
    repeat (3) tick();
    chk("decode_cur", 32'(cur_state), 64);
    cond = 4'b0010;
    #1 chk("cjump_taken_uaddr", 32'(uaddr), 1);
    tick();
    chk("cjump_taken_cur", 32'(cur_state), 1);
    tick();
    cond = 4'b1101;
    #1 chk("cjump_fall_uaddr", 32'(uaddr), 65);
    tick();
    chk("cjump_fall_cur", 32'(cur_state), 65);
    // CWAIT on cond[0]
    clear_mem();
    mem[0] = mk(1, 0, 0, 0, 10);
    mem[10] = mk(4, 0, 0, 'hABC, 0);
    mem[11] = mk(2, 0, 0, 'h11, 0);
    cond = 4'b0000;
    do_reset(1);
    repeat (2) tick();
    repeat (3) begin
      tick();
      chk("cwait_cur", 32'(cur_state), 10);
      chk("cwait_ctl", 32'(ctl), 'hABC);
    end
    cond = 4'b0001;
    tick();
    chk("cwait_exit_cur", 32'(cur_state), 11);
    chk("cwait_exit_ctl", 32'(ctl), 'h11);
    // nested call / return
    clear_mem();
`ifdef MICRO_SEQ_STACK_EN
    mem[0] = mk(1, 0, 0, 0, 20);
    mem[20] = mk(5, 0, 0, 1, 40);
    mem[40] = mk(5, 0, 0, 2, 50);
    mem[50] = mk(6, 0, 0, 3, 77);
    mem[41] = mk(6, 0, 0, 4, 77);
    mem[21] = mk(2, 0, 0, 5, 0);
    do_reset(1);
    repeat (5) tick();
    chk("ret_inner_cur", 32'(cur_state), 41);
    tick();
    chk("ret_outer_cur", 32'(cur_state), 21);
    chk("call_err", 32'(stack_err), 0);
`else
    mem[0] = mk(1, 0, 0, 0, 5);
    mem[5] = mk(5, 0, 0, 1, 30);
    mem[30] = mk(6, 0, 0, 2, 77);
    do_reset(1);
    repeat (3) tick();
    chk("call_as_jump_cur", 32'(cur_state), 30);
    tick();
    chk("ret_zero_cur", 32'(cur_state), 0);
    chk("nostack_err", 32'(stack_err), 0);
`endif
    // overflow, then underflow
    clear_mem();
    mem[0] = mk(5, 0, 0, 1, 1);
    mem[1] = mk(5, 0, 0, 2, 2);
    mem[2] = mk(5, 0, 0, 3, 3);
    mem[3] = mk(6, 0, 0, 4, 77);
    do_reset(1);
    repeat (4) tick();
    chk("ovf_cur", 32'(cur_state), 3);
`ifdef MICRO_SEQ_STACK_EN
    chk("ovf_err", 32'(stack_err), 1);
    tick();
    chk("ovf_ret_cur", 32'(cur_state), 2);
`else
    chk("ovf_err", 32'(stack_err), 0);
    tick();
    chk("ovf_ret_cur", 32'(cur_state), 0);
`endif
    clear_mem();
    mem[0] = mk(6, 0, 0, 9, 77);
    do_reset(1);
    tick();
    chk("unf_err_pre", 32'(stack_err), 0);
    tick();
    chk("unf_cur", 32'(cur_state), 0);
`ifdef MICRO_SEQ_STACK_EN
    chk("unf_err", 32'(stack_err), 1);
`else
    chk("unf_err", 32'(stack_err), 0);
`endif
    // randomized programs with random conditions, decode entries and resets
    for (int i = 0; i < DEPTH; i++)
      mem[i] = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                  int'($urandom), $urandom_range(0, DEPTH - 1));
    do_reset(2);
    repeat (3000) begin
      cond = NC'($urandom);
      decode_addr = AW'($urandom);
      reset = $urandom_range(0, 49) != 0;
      tick();
    end
    reset = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
